// File: rtl/zion_basic_circuit_lib_dff_pipe_pkg.sv
// Shared constants and helpers for the valid/ready register pipe.
package zion_basic_circuit_lib_dff_pipe_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // True when a requested stage count lies inside the supported range.
    function automatic logic depth_is_legal(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

    // Number of set bits in a stage-valid vector (zero-extended to DEPTH_MAX).
    function automatic int unsigned count_ones(input logic [DEPTH_MAX-1:0] bits);
        int unsigned total;
        total = 0;
        for (int i = 0; i < DEPTH_MAX; i++) begin
            total = total + int'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_dff_pipe_stage.sv
// One valid/ready register slice. The slice captures its source whenever the
// parent says it may load; a flush empties it without touching the data.
module zion_basic_circuit_lib_dff_pipe_stage
    import zion_basic_circuit_lib_dff_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // Valid bit: cleared by reset or flush, otherwise follows the source on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= src_vld;
        end
    end

    // Data register: only overwritten by a real item, so stalls and bubbles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat <= '0;
        end else if (!flush && load && src_vld) begin
            dat <= src_dat;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_dff_pipe.sv
// DEPTH-stage valid/ready register pipe with bubble collapsing, a synchronous
// flush and an occupancy count. Ready ripples combinationally from iRdy back
// to oRdy so a fully streaming pipe moves one item per clock.

`ifndef ZION_BASIC_CIRCUIT_LIB_DFF_PIPE_MACRO
`define ZION_BASIC_CIRCUIT_LIB_DFF_PIPE_MACRO
`define ZION_BASIC_CIRCUIT_LIB_DFF_PIPE(inst_name, clk_s, rst_n_s, ivld_s, ordy_s, idat_s, ovld_s, irdy_s, odat_s, iflush_s, ocnt_s, depth_v) \
    zion_basic_circuit_lib_dff_pipe #( \
        .WIDTH_IN ($bits(idat_s)), \
        .WIDTH_OUT($bits(odat_s)), \
        .DEPTH    (depth_v) \
    ) inst_name ( \
        .clk   (clk_s), \
        .rst_n (rst_n_s), \
        .iVld  (ivld_s), \
        .oRdy  (ordy_s), \
        .iDat  (idat_s), \
        .oVld  (ovld_s), \
        .iRdy  (irdy_s), \
        .oDat  (odat_s), \
        .iFlush(iflush_s), \
        .oCnt  (ocnt_s) \
    );
`endif

module zion_basic_circuit_lib_dff_pipe
    import zion_basic_circuit_lib_dff_pipe_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 8,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat,
    input  logic                 iFlush,
    output logic [CNT_W-1:0]     oCnt
);

`ifndef SYNTHESIS
    // Reject parameter sets the pipe cannot honour before any simulation time passes.
    initial begin : param_check
        if (WIDTH_IN != WIDTH_OUT || !depth_is_legal(DEPTH)) begin
            $error("zion_basic_circuit_lib_dff_pipe: illegal parameters WIDTH_IN=%0d WIDTH_OUT=%0d DEPTH=%0d",
                   WIDTH_IN, WIDTH_OUT, DEPTH);
`ifdef CHECK_ERR_EXIT
            $finish;
`endif
        end
    end
`endif

    logic [DEPTH-1:0]    stage_vld;
    logic [WIDTH_IN-1:0] stage_dat [DEPTH];
    logic [DEPTH-1:0]    stage_load;
    logic [DEPTH-1:0]    src_vld;
    logic [WIDTH_IN-1:0] src_dat [DEPTH];
    logic                out_vld;

    // A flush hides the last stage so no output handshake can complete that cycle.
    always_comb begin
        out_vld = stage_vld[DEPTH-1] && !iFlush;
    end

    // Ready chain: a stage may load if it is empty or its occupant moves on this cycle.
    always_comb begin
        stage_load = '0;
        stage_load[DEPTH-1] = !stage_vld[DEPTH-1] || (out_vld && iRdy);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            stage_load[k] = !stage_vld[k] || stage_load[k+1];
        end
    end

    // Each stage is fed by its upstream neighbour; stage 0 is fed by the input port.
    always_comb begin
        src_vld    = '0;
        src_vld[0] = iVld;
        src_dat[0] = iDat;
        for (int k = 1; k < DEPTH; k++) begin
            src_vld[k] = stage_vld[k-1];
            src_dat[k] = stage_dat[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        zion_basic_circuit_lib_dff_pipe_stage #(
            .WIDTH(WIDTH_IN)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (iFlush),
            .load   (stage_load[k]),
            .src_vld(src_vld[k]),
            .src_dat(src_dat[k]),
            .vld    (stage_vld[k]),
            .dat    (stage_dat[k])
        );
    end

    // Drive the handshake outputs, masking both sides while a flush is requested.
    always_comb begin
        oRdy = stage_load[0] && !iFlush;
        oVld = out_vld;
        oDat = WIDTH_OUT'(stage_dat[DEPTH-1]);
    end

    // Occupancy is the number of stages currently holding a valid item.
    always_comb begin
        oCnt = CNT_W'(count_ones(DEPTH_MAX'(stage_vld)));
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_dff_pipe.sv
// Directed and randomised checks of the 3-deep, 8-bit register pipe.
module tb_zion_basic_circuit_lib_dff_pipe;

    localparam int DEPTH = 3;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;
    logic             iFlush;
    logic [CNT_W-1:0] oCnt;

    int total;
    int bad;
    logic [WIDTH-1:0] sb_q[$];

    zion_basic_circuit_lib_dff_pipe #(
        .WIDTH_IN (WIDTH),
        .WIDTH_OUT(WIDTH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iVld  (iVld),
        .oRdy  (oRdy),
        .iDat  (iDat),
        .oVld  (oVld),
        .iRdy  (iRdy),
        .oDat  (oDat),
        .iFlush(iFlush),
        .oCnt  (oCnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] dat, input logic rdy, input logic flush);
        iVld   = vld;
        iDat   = dat;
        iRdy   = rdy;
        iFlush = flush;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (DEPTH + 1) step();
    endtask

    // One randomised cycle: check occupancy against the scoreboard, then log handshakes.
    task automatic randomCycle(input logic vld, input logic [WIDTH-1:0] dat, input logic rdy);
        applyStimulus(vld, dat, rdy, 1'b0);
        @(negedge clk);
        checkOutput("rand_cnt", 32'(oCnt), 32'(sb_q.size()));
        if (sb_q.size() == 0) begin
            checkOutput("rand_empty_vld", 32'(oVld), 32'd0);
            checkOutput("rand_empty_rdy", 32'(oRdy), 32'd1);
        end
        if (sb_q.size() == DEPTH && !rdy) begin
            checkOutput("rand_full_rdy", 32'(oRdy), 32'd0);
        end
        if (oVld && rdy) begin
            if (sb_q.size() == 0) begin
                checkOutput("rand_spurious", 32'(oVld), 32'd0);
            end else begin
                checkOutput("rand_order", 32'(oDat), 32'(sb_q.pop_front()));
            end
        end
        if (vld && oRdy) begin
            sb_q.push_back(dat);
        end
        step();
    endtask

    initial begin
        int exp_cnt;
        total = 0;
        bad   = 0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_vld", 32'(oVld), 32'd0);
        checkOutput("rst_dat", 32'(oDat), 32'd0);
        checkOutput("rst_cnt", 32'(oCnt), 32'd0);
        checkOutput("rst_rdy", 32'(oRdy), 32'd1);
        step();
        rst_n = 1'b1;

        // Streaming 0x01..0x0A with downstream always ready
        for (int i = 0; i < 14; i++) begin
            if (i < 10) applyStimulus(1'b1, 8'(i + 1), 1'b1, 1'b0);
            else        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            if (i >= 3 && i <= 12) begin
                checkOutput("stream_vld", 32'(oVld), 32'd1);
                checkOutput("stream_dat", 32'(oDat), 32'(i - 2));
            end else begin
                checkOutput("stream_idle", 32'(oVld), 32'd0);
            end
            exp_cnt = (i < 3) ? i : ((i <= 10) ? 3 : 13 - i);
            checkOutput("stream_cnt", 32'(oCnt), 32'(exp_cnt));
            if (i < 10) checkOutput("stream_rdy", 32'(oRdy), 32'd1);
            step();
        end
        drain();

        // Backpressure: three items fill the pipe, the fourth is refused
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0); @(negedge clk);
        checkOutput("bp_rdy0", 32'(oRdy), 32'd1); step();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0); @(negedge clk);
        checkOutput("bp_rdy1", 32'(oRdy), 32'd1); step();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0); @(negedge clk);
        checkOutput("bp_rdy2", 32'(oRdy), 32'd1); step();
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0); @(negedge clk);
        checkOutput("bp_full_rdy", 32'(oRdy), 32'd0);
        checkOutput("bp_full_cnt", 32'(oCnt), 32'd3);
        checkOutput("bp_hold_dat", 32'(oDat), 32'h11);
        step();
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0); @(negedge clk);
        checkOutput("bp_release_rdy", 32'(oRdy), 32'd1);
        checkOutput("bp_out0", 32'(oDat), 32'h11);
        checkOutput("bp_out0_vld", 32'(oVld), 32'd1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk);
        checkOutput("bp_out1", 32'(oDat), 32'h22);
        checkOutput("bp_both_cnt", 32'(oCnt), 32'd3);
        step(); @(negedge clk);
        checkOutput("bp_out2", 32'(oDat), 32'h33);
        checkOutput("bp_cnt2", 32'(oCnt), 32'd2);
        step(); @(negedge clk);
        checkOutput("bp_out3", 32'(oDat), 32'h44);
        checkOutput("bp_out3_vld", 32'(oVld), 32'd1);
        step(); @(negedge clk);
        checkOutput("bp_empty_vld", 32'(oVld), 32'd0);
        checkOutput("bp_empty_cnt", 32'(oCnt), 32'd0);
        drain();

        // Bubble collapse: a later item closes up behind a stalled head
        applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0); step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); repeat (5) step();
        applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0); @(negedge clk);
        checkOutput("bub_push_rdy", 32'(oRdy), 32'd1); step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); step(); @(negedge clk);
        checkOutput("bub_cnt", 32'(oCnt), 32'd2);
        checkOutput("bub_head", 32'(oDat), 32'hA0);
        checkOutput("bub_rdy", 32'(oRdy), 32'd1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk);
        checkOutput("bub_out0", 32'(oDat), 32'hA0);
        step(); @(negedge clk);
        checkOutput("bub_out1_vld", 32'(oVld), 32'd1);
        checkOutput("bub_out1", 32'(oDat), 32'hB0);
        step(); @(negedge clk);
        checkOutput("bub_done", 32'(oCnt), 32'd0);
        drain();

        // Flush: a full pipe empties and the item offered alongside the flush is lost
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0); step();
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0); step();
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0); step();
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1); @(negedge clk);
        checkOutput("fl_rdy_mask", 32'(oRdy), 32'd0);
        checkOutput("fl_vld_mask", 32'(oVld), 32'd0);
        checkOutput("fl_cnt_before", 32'(oCnt), 32'd3);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk);
        checkOutput("fl_cnt", 32'(oCnt), 32'd0);
        checkOutput("fl_vld", 32'(oVld), 32'd0);
        checkOutput("fl_dat_kept", 32'(oDat), 32'hC1);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("fl_no_55", 32'(oVld), 32'd0);
            step();
        end

        // Asynchronous reset in the middle of a stream
        applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0); step();
        applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0); step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); step();
        @(negedge clk);
        checkOutput("mr_pre_dat", 32'(oDat), 32'hD1);
        checkOutput("mr_pre_cnt", 32'(oCnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_vld", 32'(oVld), 32'd0);
        checkOutput("mr_dat", 32'(oDat), 32'd0);
        checkOutput("mr_cnt", 32'(oCnt), 32'd0);
        checkOutput("mr_rdy", 32'(oRdy), 32'd1);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j == 0)      applyStimulus(1'b1, 8'hE1, 1'b1, 1'b0);
            else if (j == 1) applyStimulus(1'b1, 8'hE2, 1'b1, 1'b0);
            else             applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            if (j < 3) begin
                checkOutput("mr_wait_vld", 32'(oVld), 32'd0);
            end else begin
                checkOutput("mr_first_vld", 32'(oVld), 32'd1);
                checkOutput("mr_first_dat", 32'(oDat), 32'hE1);
            end
            step();
        end
        drain();

        // Randomised handshakes against a FIFO scoreboard
        sb_q.delete();
        for (int n = 0; n < 10000; n++) begin
            randomCycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < DEPTH + 2; n++) begin
            randomCycle(1'b0, 8'h00, 1'b1);
        end
        checkOutput("rand_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
